// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-handshake and arbiter types for the multicore MIPS memory path.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef enum logic {CLS_I, CLS_D} arb_class_t;
endpackage

// File: rtl/memory_arbiter_rr_pick2.sv
// rr_pick2: two-request round-robin picker; on a tie the core other than last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);
  always_comb begin
    any = |req;
    gnt = &req ? ~last : req[1];
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between both cores' icaches and dcaches, dcache first.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic      [CPUS-1:0] iREN,
  input  word_t     [CPUS-1:0] iaddr,
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  output logic      [CPUS-1:0] iwait,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] iload,
  output word_t     [CPUS-1:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);
  arb_state_t state;
  arb_class_t cls;
  logic core, ptr_i, ptr_d;
  logic gnt_i, gnt_d, any_i, any_d;
  logic live, busy, wr, done;
  rr_pick2 u_pick_i (.req(iREN[1:0]), .last(ptr_i), .gnt(gnt_i), .any(any_i));
  rr_pick2 u_pick_d (.req(dREN[1:0] | dWEN[1:0]), .last(ptr_d), .gnt(gnt_d), .any(any_d));
  // a winner that drops its request mid-grant aborts without completing
  always_comb begin
    live = cls == CLS_D ? dREN[core] | dWEN[core] : iREN[core];
    busy = state == GRANT && live;
    wr = busy && cls == CLS_D && dWEN[core];
    done = busy && ramstate == ACCESS;
    ramWEN = wr;
    ramREN = busy && !wr;
    ramaddr = state == GRANT ? (cls == CLS_D ? daddr[core] : iaddr[core]) : '0;
    ramstore = state == GRANT && cls == CLS_D ? dstore[core] : '0;
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (done && cls == CLS_D) begin
      dwait[core] = 1'b0;
      dload[core] = ramload;
    end
    if (done && cls == CLS_I) begin
      iwait[core] = 1'b0;
      iload[core] = ramload;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cls <= CLS_I;
      core <= 1'b0;
      ptr_i <= 1'b0;
      ptr_d <= 1'b0;
    end else if (state == IDLE) begin
      if (any_d || any_i) begin
        state <= GRANT;
        cls <= any_d ? CLS_D : CLS_I;
        core <= any_d ? gnt_d : gnt_i;
      end
    end else if (!live || ramstate == ACCESS) begin
      state <= IDLE;
      if (done && cls == CLS_D) ptr_d <= core;
      if (done && cls == CLS_I) ptr_i <= core;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench; expected transfers are queued at stimulus time and popped on each wait pulse.
module tb_memory_arbiter;
  import cpu_types_pkg::*;
  localparam word_t K = 32'h5A5A_0000;
  typedef struct {
    logic  cls;
    logic  core;
    word_t addr;
    logic  we;
    word_t store;
  } exp_t;
  logic CLK = 0, RST;
  logic [1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t [1:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0, pulses = 0, cycle = 0;
  int c, prev, p0;
  logic act_cls, act_core;
  word_t ld;
  memory_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );
  assign ramload = ramaddr ^ K;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input logic cls, input logic core, input word_t addr, input logic we, input word_t store);
    exp_t x;
    x.cls = cls; x.core = core; x.addr = addr; x.we = we; x.store = store;
    sb.push_back(x);
  endtask
  task automatic wait_pulse(output int cyc);
    int n;
    n = 0;
    @(negedge CLK);
    while ({iwait, dwait} == 4'hF && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("pulse_timeout", n < 40, 1);
    cyc = cycle;
  endtask
  always @(negedge CLK) begin
    if (RST === 1'b0 && {iwait, dwait} != 4'hF) begin
      pulses++;
      chk("one_wait", $countones(~{iwait, dwait}), 1);
      if (sb.size() == 0) chk("unexpected_pulse", {iwait, dwait}, 4'hF);
      else begin
        e = sb.pop_front();
        act_cls = dwait != 2'b11;
        act_core = act_cls ? dwait[0] : iwait[0];
        ld = act_cls ? dload[act_core] : iload[act_core];
        chk("grant_who", {act_cls, act_core}, {e.cls, e.core});
        chk("xfer_addr", ramaddr, e.addr);
        chk("xfer_wen", ramWEN, e.we);
        chk("xfer_ren", ramREN, !e.we);
        if (e.we) chk("xfer_store", ramstore, e.store);
        chk("xfer_load", ld, e.addr ^ K);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    RST = 1; iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11; ramstate = BUSY;
    iaddr[0] = 32'h20; iaddr[1] = 32'h24; daddr[0] = 32'h28; daddr[1] = 32'h2C;
    dstore[0] = 32'hAAAA_0000; dstore[1] = 32'hBBBB_0001;
    tick; tick;
    chk("rst_waits", {iwait, dwait}, 4'hF);
    chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    // pointers reset to 0, so a dcache tie goes to core 1; both strobes high means write
    RST = 0;
    tick;
    chk("first_grant_addr", ramaddr, 32'h2C);
    chk("first_grant_wen", {ramREN, ramWEN}, 2'b01);
    iREN = 0; dREN = 0; dWEN = 0;
    tick;
    chk("abort_idle_addr", ramaddr, 0);
    // class priority: dcache1 beats icache0, then icache0 after one idle cycle
    iREN = 2'b01; dREN = 2'b10; iaddr[0] = 32'h100; daddr[1] = 32'h200;
    push(1, 1, 32'h200, 0, 0);
    push(0, 0, 32'h100, 0, 0);
    tick;
    chk("prio_addr", ramaddr, 32'h200);
    tick; tick;
    ramstate = ACCESS;
    wait_pulse(prev);
    tick;
    dREN = 0;
    wait_pulse(c);
    chk("prio_gap", c - prev, 2);
    tick;
    iREN = 0;
    // round-robin among held dcache writes; last dcache winner was core 1
    dWEN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h14;
    dstore[0] = 32'h1111_1111; dstore[1] = 32'h2222_2222;
    push(1, 0, 32'h10, 1, 32'h1111_1111);
    push(1, 1, 32'h14, 1, 32'h2222_2222);
    push(1, 0, 32'h10, 1, 32'h1111_1111);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(c);
      if (k > 0) chk("rr_gap", c - prev, 2);
      prev = c;
    end
    tick;
    dWEN = 0;
    // write takes precedence over read
    dREN = 2'b01; dWEN = 2'b01; daddr[0] = 32'h40; dstore[0] = 32'hDEAD_BEEF; ramstate = BUSY;
    tick;
    chk("wp_strobes", {ramREN, ramWEN}, 2'b01);
    chk("wp_store", ramstore, 32'hDEAD_BEEF);
    push(1, 0, 32'h40, 1, 32'hDEAD_BEEF);
    ramstate = ACCESS;
    wait_pulse(c);
    tick;
    dREN = 0; dWEN = 0;
    // ERROR is retried with the grant held
    p0 = pulses;
    dREN = 2'b10; daddr[1] = 32'h80; ramstate = ERROR;
    push(1, 1, 32'h80, 0, 0);
    tick;
    chk("err_addr", ramaddr, 32'h80);
    tick; tick;
    chk("err_hold", {ramREN, ramaddr}, {1'b1, 32'h80});
    ramstate = ACCESS;
    wait_pulse(c);
    tick;
    dREN = 0;
    tick; tick;
    chk("err_pulses", pulses - p0, 1);
    // abort leaves the icache pointer at 0, so a later tie goes to core 1
    p0 = pulses;
    iREN = 2'b10; iaddr[1] = 32'h300; ramstate = BUSY;
    tick;
    chk("abort_grant", {ramREN, ramaddr}, {1'b1, 32'h300});
    iREN = 0; ramstate = ACCESS;
    tick;
    chk("abort_idle", {ramREN, ramWEN, ramaddr}, 34'h0);
    chk("abort_pulses", pulses - p0, 0);
    iREN = 2'b11; iaddr[0] = 32'h104;
    push(0, 1, 32'h300, 0, 0);
    wait_pulse(c);
    tick;
    iREN = 0;
    tick;
    // reset while granted and RAM busy
    p0 = pulses;
    dREN = 2'b01; daddr[0] = 32'h60; ramstate = BUSY;
    tick;
    chk("rm_grant", ramREN, 1);
    RST = 1;
    tick;
    chk("rm_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rm_addr", ramaddr, 0);
    chk("rm_waits", {iwait, dwait}, 4'hF);
    RST = 0; dREN = 0; ramstate = ACCESS;
    tick; tick;
    chk("rm_pulses", pulses - p0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
